dnlink_rx: RTL and testbench
============================

# dnlink_rx

Downlink telemetry receiver: the ground/PCM end of the AGC digital downlink. It generates the DKSTRT / DKBSNC / DKEND strobes paced by the AGC `CLK` output and samples the AGC's `DKDATA` line during each bit strobe. It assembles 40-bit downlink words and hands them to the monitor over a valid/ready handshake. It replaces the free-running strobe generator in the top level and sits between the `fpga_agc` downlink pins and the monitor's UART path.

## Interface
Parameters:
- `PULSE_DIV`, 20: `agc_clk` rising edges per bit slot.
- `STROBE_LEN`, 4: edges per slot during which a strobe is high.
- `FRAME_SLOTS`, 1024: bit slots per frame. Must be at least 43.
- `FIFO_DEPTH`, 4: output word FIFO depth. Power of two. Used only with `DNLINK_FIFO_EN`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `agc_clk` in 1: AGC `CLK` output. Asynchronous to `clk`.
- `dkdata` in 1: AGC `DKDATA`. Asynchronous to `clk`.
- `dkstrt`, `dkbsnc`, `dkend` out 1 each: strobes to the AGC. Registered.
- `word` out 40: received word. Bit 40 is the first bit received.
- `word_valid` out 1, `word_ready` in 1: output handshake.
- `overrun` out 1: one-cycle pulse when a completed word is dropped.
- `frame_active` out 1: high from the START slot through the END slot.

## Operation
- `agc_clk` passes through a 2-flop synchronizer and a rising-edge detector, producing `tick` (one `clk` cycle wide). `dkdata` passes through its own 2-flop synchronizer.
- `edge_cnt` runs 0..PULSE_DIV-1 and advances on each `tick`.
  - On wrap, `slot` advances.
  - On wrap, `frame_cnt` (0..FRAME_SLOTS-1, wrapping) also increments.
- Slot FSM:
  - GAP → START when `frame_cnt` wraps to 0.
  - START → BIT, with `bitn` = 1.
  - BIT advances `bitn` on each slot wrap. After `bitn` = 40 it goes to END.
  - END → GAP.
- Strobe outputs:
  - `dkstrt` = START && `edge_cnt` < STROBE_LEN.
  - `dkbsnc` = BIT && `edge_cnt` < STROBE_LEN.
  - `dkend` = END && `edge_cnt` < STROBE_LEN.
  - All three are registered, so each is one `clk` cycle behind the state.
- Sampling: in BIT, on the `tick` where `edge_cnt` goes STROBE_LEN-1 → STROBE_LEN, the synchronized `dkdata` shifts into the LSB of a 40-bit shift register. `dkdata` is ignored in the START, END and GAP slots.
- The word completes at the bit-40 sample and is offered one cycle later.
- Handshake:
  - A transfer occurs when `word_valid` && `word_ready`.
  - `word` is stable while `word_valid` is high and not yet accepted.
  - `word_ready` may be high with no word pending.
- Output register full at completion:
  - If `word_ready` is high in the same cycle, the old word transfers, the new word loads, and `word_valid` stays high.
  - Otherwise the new word is dropped, the old word is kept, and `overrun` pulses.
- Reset values:
  - Strobes 0, `word_valid` 0, `word` 0, `overrun` 0, `frame_active` 0.
  - FSM in GAP, `frame_cnt` = FRAME_SLOTS-1, `edge_cnt` = 0.
  - Reset mid-frame discards the partial word and deasserts the strobes immediately.

## Timing
- Tick latency is 3 `clk` cycles after an `agc_clk` rising edge (2 sync flops plus the edge detector).
- The first `dkstrt` rises 1 `clk` cycle after the 20th tick following reset deassertion.
- Each strobe is high for STROBE_LEN ticks. Slot period is PULSE_DIV ticks.
- Frame period is FRAME_SLOTS × PULSE_DIV ticks. With defaults, frames start every 20480 ticks.
- `word_valid` rises 1 `clk` cycle after the bit-40 sampling tick.
- `dkend` follows the bit-40 slot by exactly one slot.

## Configuration
- `DNLINK_FIFO_EN` defined: completed words enter a FIFO_DEPTH-entry FIFO.
  - `word`/`word_valid` present the FIFO head.
  - `overrun` pulses only when the FIFO is full at completion and no pop occurs in that cycle.
  - A simultaneous push and pop at full is accepted.
- Undefined: a single output register with the drop rule from Operation.

## Structure
- `dnlink_pkg`: slot-state enum (GAP, START, BIT, END) and the constant `DNLINK_WORD_BITS` = 40.
- Sub-module `dnlink_word_fifo` (40-bit synchronous FIFO, same `clk`/`rst`). Instantiated only under `DNLINK_FIFO_EN`.

## Test plan
- Reset, then 25000 `agc_clk` edges → the first `dkstrt` follows the 20th edge; next `dkstrt` after 20480 more edges; 40 `dkbsnc` pulses and 1 `dkend` per frame, each 4 edges wide.
- Drive `dkdata` with the pattern 0xA5_5A3C_C3F0 MSB-first, changing only while strobes are low → `word` = 40'hA55A3CC3F0 with `word_valid` high; `word_ready` pulse clears it.
- Hold `dkdata` = 1 during START/END slots and 0 during all bit slots → `word` = 0.
- `word_ready` held low across two frames, FIFO disabled → the first word is retained and `overrun` pulses once at the second completion. FIFO enabled → no overrun until the 5th word.
- Assert `rst` at bit 17 for 2 cycles → strobes low immediately, no word produced, next `dkstrt` again after 20 ticks.
- `word_ready` high in the exact completion cycle with a word pending → the old word transfers, the new word is presented next cycle, no `overrun`.

Source files
------------

// File: rtl/dnlink_pkg.sv
// dnlink_pkg: shared types and constants for the AGC downlink receiver.
package dnlink_pkg;

   localparam int unsigned DNLINK_WORD_BITS = 40;

   typedef enum logic [1:0] {
      StGap,
      StStart,
      StBit,
      StEnd
   } slot_state_e;

endpackage

// File: rtl/dnlink_rx_if.sv
// dnlink_rx_if: valid/ready word handoff from the downlink receiver to the monitor.
interface dnlink_rx_if;
   import dnlink_pkg::*;

   logic [DNLINK_WORD_BITS-1:0] word;
   logic                        word_valid;
   logic                        word_ready;

   modport master (output word, output word_valid, input word_ready);
   modport slave  (input word, input word_valid, output word_ready);

endinterface

// File: rtl/dnlink_word_fifo.sv
// dnlink_word_fifo: synchronous FIFO of downlink words; a push at full is taken only with a pop.
module dnlink_word_fifo
   import dnlink_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push_i,
   input  logic [DNLINK_WORD_BITS-1:0] data_i,
   input  logic                        pop_i,
   output logic [DNLINK_WORD_BITS-1:0] head_o,
   output logic                        full_o,
   output logic                        empty_o
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DNLINK_WORD_BITS-1:0] mem_q [DEPTH];
   logic [AW-1:0]               wptr_q, rptr_q;
   logic [AW:0]                 cnt_q;
   logic                        push_ok, pop_ok;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW + 1)'(DEPTH));
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);
   assign head_o  = mem_q[rptr_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wptr_q] <= data_i;
            wptr_q        <= wptr_q + 1'b1;
         end
         if (pop_ok) rptr_q <= rptr_q + 1'b1;
         if (push_ok && !pop_ok) cnt_q <= cnt_q + 1'b1;
         else if (pop_ok && !push_ok) cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/dnlink_rx.sv
// dnlink_rx: AGC downlink receiver -- DKSTRT/DKBSNC/DKEND strobes, DKDATA sampling, word handoff.
// Define DNLINK_FIFO_EN to queue completed words in dnlink_word_fifo instead of one register.
module dnlink_rx
   import dnlink_pkg::*;
#(
   parameter int unsigned PULSE_DIV   = 20,
   parameter int unsigned STROBE_LEN  = 4,
   parameter int unsigned FRAME_SLOTS = 1024,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        agc_clk,
   input  logic        dkdata,
   output logic        dkstrt,
   output logic        dkbsnc,
   output logic        dkend,
   output logic        overrun,
   output logic        frame_active,
   dnlink_rx_if.master out_if
);
   localparam int unsigned   EW         = (PULSE_DIV > 1) ? $clog2(PULSE_DIV) : 1;
   localparam int unsigned   FW         = $clog2(FRAME_SLOTS);
   localparam logic [EW-1:0] EdgeLast   = EW'(PULSE_DIV - 1);
   localparam logic [EW-1:0] StrobeLen  = EW'(STROBE_LEN);
   localparam logic [EW-1:0] StrobeLast = EW'(STROBE_LEN - 1);
   localparam logic [FW-1:0] FrameLast  = FW'(FRAME_SLOTS - 1);
   localparam logic [5:0]    LastBit    = 6'(DNLINK_WORD_BITS);

   if (FRAME_SLOTS < 43 || STROBE_LEN >= PULSE_DIV || FIFO_DEPTH == 0 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("dnlink_rx: illegal parameter combination");
   end

   logic [1:0]                  agc_sync_q, dk_sync_q;
   logic                        agc_prev_q, tick_q;
   logic [EW-1:0]               edge_q, edge_d;
   logic [FW-1:0]               frame_q, frame_d;
   slot_state_e                 state_q, state_d;
   logic [5:0]                  bitn_q, bitn_d;
   logic [DNLINK_WORD_BITS-1:0] shreg_q, shreg_d;
   logic                        dkstrt_d, dkbsnc_d, dkend_d, frame_active_d, overrun_d;
   logic                        slot_wrap, strobe_on, sample, complete;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         agc_sync_q <= '0;
         agc_prev_q <= 1'b0;
         tick_q     <= 1'b0;
         dk_sync_q  <= '0;
      end else begin
         agc_sync_q <= {agc_sync_q[0], agc_clk};
         agc_prev_q <= agc_sync_q[1];
         tick_q     <= agc_sync_q[1] & ~agc_prev_q;
         dk_sync_q  <= {dk_sync_q[0], dkdata};
      end
   end

   always_comb begin
      edge_d    = edge_q;
      frame_d   = frame_q;
      slot_wrap = 1'b0;
      if (tick_q) begin
         if (edge_q == EdgeLast) begin
            edge_d    = '0;
            slot_wrap = 1'b1;
            frame_d   = (frame_q == FrameLast) ? '0 : frame_q + 1'b1;
         end else begin
            edge_d = edge_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      bitn_d  = bitn_q;
      if (slot_wrap) begin
         unique case (state_q)
            StGap:   if (frame_q == FrameLast) state_d = StStart;
            StStart: begin
               state_d = StBit;
               bitn_d  = 6'd1;
            end
            StBit:   if (bitn_q == LastBit) state_d = StEnd;
                     else bitn_d = bitn_q + 6'd1;
            StEnd:   state_d = StGap;
            default: state_d = StGap;
         endcase
      end
      strobe_on      = (edge_q < StrobeLen);
      dkstrt_d       = (state_q == StStart) && strobe_on;
      dkbsnc_d       = (state_q == StBit) && strobe_on;
      dkend_d        = (state_q == StEnd) && strobe_on;
      frame_active_d = (state_q != StGap);
      // DKDATA is taken on the tick that ends the bit strobe.
      sample   = tick_q && (state_q == StBit) && (edge_q == StrobeLast);
      shreg_d  = sample ? {shreg_q[DNLINK_WORD_BITS-2:0], dk_sync_q[1]} : shreg_q;
      complete = sample && (bitn_q == LastBit);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_q       <= '0;
         frame_q      <= FrameLast;
         state_q      <= StGap;
         bitn_q       <= '0;
         shreg_q      <= '0;
         dkstrt       <= 1'b0;
         dkbsnc       <= 1'b0;
         dkend        <= 1'b0;
         frame_active <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         edge_q       <= edge_d;
         frame_q      <= frame_d;
         state_q      <= state_d;
         bitn_q       <= bitn_d;
         shreg_q      <= shreg_d;
         dkstrt       <= dkstrt_d;
         dkbsnc       <= dkbsnc_d;
         dkend        <= dkend_d;
         frame_active <= frame_active_d;
         overrun      <= overrun_d;
      end
   end

`ifdef DNLINK_FIFO_EN
   logic                        fifo_full, fifo_empty, fifo_pop;
   logic [DNLINK_WORD_BITS-1:0] fifo_head;

   assign fifo_pop          = !fifo_empty && out_if.word_ready;
   assign overrun_d         = complete && fifo_full && !fifo_pop;
   assign out_if.word       = fifo_head;
   assign out_if.word_valid = !fifo_empty;

   dnlink_word_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (complete),
      .data_i  (shreg_d),
      .pop_i   (fifo_pop),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );
`else
   logic [DNLINK_WORD_BITS-1:0] word_q, word_d;
   logic                        valid_q, valid_d;

   always_comb begin
      word_d    = word_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      if (valid_q && out_if.word_ready) valid_d = 1'b0;
      // A full register only takes the new word if the old one leaves this cycle.
      if (complete) begin
         if (!valid_q || out_if.word_ready) begin
            word_d  = shreg_d;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

   assign out_if.word       = word_q;
   assign out_if.word_valid = valid_q;
`endif

endmodule

// File: tb/tb_dnlink_rx.sv
// tb_dnlink_rx: drives agc_clk/dkdata from a slot-position model of the frame and checks strobes
// and received words against it.
`timescale 1ns/1ps
module tb_dnlink_rx;
   import dnlink_pkg::*;

   localparam int PD  = 10;
   localparam int SL  = 4;
   localparam int FS  = 48;
   localparam int FD  = 4;
   localparam int CPT = 6;  // clk cycles per agc_clk period
`ifdef DNLINK_FIFO_EN
   localparam int KEEP = FD;
`else
   localparam int KEEP = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic agc_clk = 1'b0;
   logic dkdata = 1'b0;
   logic dkstrt, dkbsnc, dkend, overrun, frame_active;

   dnlink_rx_if rx_if ();

   dnlink_rx #(
      .PULSE_DIV   (PD),
      .STROBE_LEN  (SL),
      .FRAME_SLOTS (FS),
      .FIFO_DEPTH  (FD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .agc_clk      (agc_clk),
      .dkdata       (dkdata),
      .dkstrt       (dkstrt),
      .dkbsnc       (dkbsnc),
      .dkend        (dkend),
      .overrun      (overrun),
      .frame_active (frame_active),
      .out_if       (rx_if)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          ticks = 0;
   logic [39:0] cur_word = '0;
   logic        ctl_val = 1'b0;

   // Observed strobe / handshake history, cleared by reset.
   int          rises[3];
   int          width[3];
   logic [2:0]  sprev;
   int          bad_width, ovr_cnt, end_at;
   int          strt_at[$];
   logic [39:0] xfer[$];

   always @(posedge clk) begin
      logic [2:0] sv;
      sv = {dkend, dkbsnc, dkstrt};
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            rises[i] = 0;
            width[i] = 0;
         end
         sprev = '0;
         bad_width = 0;
         ovr_cnt = 0;
         end_at = -1;
         strt_at.delete();
         xfer.delete();
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (sv[i]) width[i]++;
            if (sv[i] && !sprev[i]) begin
               rises[i]++;
               if (i == 0) strt_at.push_back(ticks);
               if (i == 2) end_at = ticks;
            end
            if (!sv[i] && sprev[i]) begin
               if (width[i] != SL * CPT) bad_width++;
               width[i] = 0;
            end
         end
         sprev = sv;
         if (overrun) ovr_cnt++;
         if (rx_if.word_valid && rx_if.word_ready) xfer.push_back(rx_if.word);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int frame_start(input int f);
      return (1 + f * FS) * PD;
   endfunction

   function automatic int sample40(input int f);
      return frame_start(f) + 40 * PD + SL;
   endfunction

   // One agc_clk period; dkdata is updated after the sampling tick, for the following slot.
   task automatic agc_tick(input bit pulse_ready);
      int p;
      @(negedge clk);
      agc_clk = 1'b1;
      ticks++;
      repeat (3) @(negedge clk);
      agc_clk = 1'b0;
      if (pulse_ready) rx_if.word_ready = 1'b1;
      @(negedge clk);
      if (pulse_ready) rx_if.word_ready = 1'b0;
      @(negedge clk);
      if (ticks % PD == SL) begin
         p = (ticks / PD) % FS;
         dkdata = (p >= 1 && p <= 40) ? cur_word[40-p] : ctl_val;
      end
   endtask

   task automatic run_to(input int target);
      while (ticks < target) agc_tick(1'b0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      agc_clk = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      ticks = 0;
      dkdata = ctl_val;
   endtask

   task automatic ready_pulse();
      @(negedge clk);
      rx_if.word_ready = 1'b1;
      @(negedge clk);
      rx_if.word_ready = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rx_if.word_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++; if (dkstrt !== 1'b0) begin n_err++; $display("FAIL rst_dkstrt: got %b want 0", dkstrt); end
      n_vec++; if (dkbsnc !== 1'b0) begin n_err++; $display("FAIL rst_dkbsnc: got %b want 0", dkbsnc); end
      n_vec++; if (dkend !== 1'b0) begin n_err++; $display("FAIL rst_dkend: got %b want 0", dkend); end
      n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %b want 0", overrun); end
      n_vec++; if (frame_active !== 1'b0) begin n_err++; $display("FAIL rst_active: got %b want 0", frame_active); end
      n_vec++; if (rx_if.word_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", rx_if.word_valid); end
      n_vec++; if (rx_if.word !== 40'h0) begin n_err++; $display("FAIL rst_word: got %h want 0", rx_if.word); end
   endtask

   task automatic test_strobes();
      ctl_val = 1'b0;
      cur_word = {8'($urandom), 32'($urandom)};
      do_reset();
      run_to(PD - 1);
      n_vec++; if (rises[0] !== 0) begin n_err++; $display("FAIL early_dkstrt: got %0d want 0", rises[0]); end
      run_to(PD);
      n_vec++; if (rises[0] !== 1) begin n_err++; $display("FAIL first_dkstrt: got %0d want 1", rises[0]); end
      n_vec++; if (strt_at.size() < 1 || strt_at[0] !== PD) begin
         n_err++; $display("FAIL first_dkstrt_tick: got %0d want %0d", (strt_at.size() > 0) ? strt_at[0] : -1, PD);
      end
      n_vec++; if (frame_active !== 1'b1) begin n_err++; $display("FAIL active_start: got %b want 1", frame_active); end
      run_to(frame_start(0) + 42 * PD);
      n_vec++; if (rises[1] !== 40) begin n_err++; $display("FAIL dkbsnc_count: got %0d want 40", rises[1]); end
      n_vec++; if (rises[2] !== 1) begin n_err++; $display("FAIL dkend_count: got %0d want 1", rises[2]); end
      n_vec++; if (end_at !== frame_start(0) + 41 * PD) begin
         n_err++; $display("FAIL dkend_tick: got %0d want %0d", end_at, frame_start(0) + 41 * PD);
      end
      n_vec++; if (frame_active !== 1'b0) begin n_err++; $display("FAIL active_gap: got %b want 0", frame_active); end
      run_to(frame_start(1));
      n_vec++; if (strt_at.size() < 2 || strt_at[1] - strt_at[0] !== FS * PD) begin
         n_err++; $display("FAIL frame_period: got %0d strobes want spacing %0d", strt_at.size(), FS * PD);
      end
      n_vec++; if (bad_width !== 0) begin n_err++; $display("FAIL strobe_width: got %0d bad pulses want 0", bad_width); end
   endtask

   task automatic test_pattern(input logic [39:0] w, input logic ctl, input string name);
      ctl_val = ctl;
      cur_word = w;
      rx_if.word_ready = 1'b0;
      do_reset();
      run_to(sample40(0) - 1);
      n_vec++; if (rx_if.word_valid !== 1'b0) begin n_err++; $display("FAIL %s_early_valid: got %b want 0", name, rx_if.word_valid); end
      run_to(sample40(0));
      n_vec++; if (rx_if.word_valid !== 1'b1) begin n_err++; $display("FAIL %s_valid: got %b want 1", name, rx_if.word_valid); end
      n_vec++; if (rx_if.word !== w) begin n_err++; $display("FAIL %s_word: got %h want %h", name, rx_if.word, w); end
      ready_pulse();
      n_vec++; if (rx_if.word_valid !== 1'b0) begin n_err++; $display("FAIL %s_cleared: got %b want 0", name, rx_if.word_valid); end
      n_vec++; if (xfer.size() !== 1 || xfer[0] !== w) begin
         n_err++; $display("FAIL %s_xfer: got %0d words want 1 of %h", name, xfer.size(), w);
      end
   endtask

   task automatic test_random_stream();
      logic [39:0] exp_q[$];
      ctl_val = $urandom_range(0, 1);
      rx_if.word_ready = 1'b1;
      do_reset();
      for (int f = 0; f < 3; f++) begin
         run_to(frame_start(f));
         cur_word = {8'($urandom), 32'($urandom)};
         exp_q.push_back(cur_word);
      end
      run_to(frame_start(2) + 42 * PD);
      n_vec++; if (xfer.size() !== 3) begin n_err++; $display("FAIL stream_count: got %0d want 3", xfer.size()); end
      for (int i = 0; i < 3 && i < xfer.size(); i++) begin
         n_vec++; if (xfer[i] !== exp_q[i]) begin n_err++; $display("FAIL stream_word%0d: got %h want %h", i, xfer[i], exp_q[i]); end
      end
      n_vec++; if (ovr_cnt !== 0) begin n_err++; $display("FAIL stream_overrun: got %0d want 0", ovr_cnt); end
      rx_if.word_ready = 1'b0;
   endtask

   task automatic test_overrun();
      logic [39:0] w[KEEP+1];
      ctl_val = 1'b1;
      rx_if.word_ready = 1'b0;
      do_reset();
      for (int f = 0; f <= KEEP; f++) begin
         run_to(frame_start(f));
         w[f] = {8'($urandom), 32'($urandom)};
         cur_word = w[f];
         run_to(sample40(f) - 1);
         n_vec++; if (ovr_cnt !== 0) begin n_err++; $display("FAIL ovr_early%0d: got %0d want 0", f, ovr_cnt); end
         run_to(sample40(f));
      end
      run_to(sample40(KEEP) + 2);
      n_vec++; if (ovr_cnt !== 1) begin n_err++; $display("FAIL ovr_count: got %0d want 1", ovr_cnt); end
      n_vec++; if (rx_if.word !== w[0]) begin n_err++; $display("FAIL ovr_kept: got %h want %h", rx_if.word, w[0]); end
      for (int i = 0; i < KEEP; i++) ready_pulse();
      n_vec++; if (xfer.size() !== KEEP) begin n_err++; $display("FAIL ovr_drain: got %0d want %0d", xfer.size(), KEEP); end
      for (int i = 0; i < KEEP && i < xfer.size(); i++) begin
         n_vec++; if (xfer[i] !== w[i]) begin n_err++; $display("FAIL ovr_word%0d: got %h want %h", i, xfer[i], w[i]); end
      end
      n_vec++; if (rx_if.word_valid !== 1'b0) begin n_err++; $display("FAIL ovr_empty: got %b want 0", rx_if.word_valid); end
   endtask

   task automatic test_reset_mid_frame();
      ctl_val = 1'b0;
      cur_word = {8'($urandom), 32'($urandom)};
      rx_if.word_ready = 1'b0;
      do_reset();
      run_to(frame_start(0) + 17 * PD);
      n_vec++; if (dkbsnc !== 1'b1) begin n_err++; $display("FAIL mid_bit17_strobe: got %b want 1", dkbsnc); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_vec++; if (dkbsnc !== 1'b0) begin n_err++; $display("FAIL mid_strobe_low: got %b want 0", dkbsnc); end
      n_vec++; if (frame_active !== 1'b0) begin n_err++; $display("FAIL mid_active_low: got %b want 0", frame_active); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ticks = 0;
      dkdata = ctl_val;
      run_to(PD - 1);
      n_vec++; if (rises[0] !== 0) begin n_err++; $display("FAIL mid_early_dkstrt: got %0d want 0", rises[0]); end
      run_to(PD);
      n_vec++; if (rises[0] !== 1 || dkstrt !== 1'b1) begin n_err++; $display("FAIL mid_dkstrt: got %0d/%b want 1/1", rises[0], dkstrt); end
      n_vec++; if (rx_if.word_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_word: got %b want 0", rx_if.word_valid); end
   endtask

   task automatic test_back_to_back();
      logic [39:0] w0, w1;
      ctl_val = 1'b1;
      w0 = {8'($urandom), 32'($urandom)};
      w1 = {8'($urandom), 32'($urandom)};
      cur_word = w0;
      rx_if.word_ready = 1'b0;
      do_reset();
      run_to(frame_start(1));
      cur_word = w1;
      run_to(sample40(1) - 1);
      n_vec++; if (rx_if.word !== w0 || rx_if.word_valid !== 1'b1) begin
         n_err++; $display("FAIL b2b_pending: got %h/%b want %h/1", rx_if.word, rx_if.word_valid, w0);
      end
      agc_tick(1'b1);
      @(posedge clk);
      #1;
      n_vec++; if (xfer.size() !== 1 || xfer[0] !== w0) begin n_err++; $display("FAIL b2b_old_xfer: got %0d words want 1 of %h", xfer.size(), w0); end
      n_vec++; if (rx_if.word !== w1 || rx_if.word_valid !== 1'b1) begin
         n_err++; $display("FAIL b2b_new_word: got %h/%b want %h/1", rx_if.word, rx_if.word_valid, w1);
      end
      n_vec++; if (ovr_cnt !== 0) begin n_err++; $display("FAIL b2b_overrun: got %0d want 0", ovr_cnt); end
   endtask

   initial begin
      test_reset();
      test_strobes();
      test_pattern(40'hA55A3CC3F0, 1'b0, "pattern");
      test_pattern(40'h0, 1'b1, "zeros");
      test_random_stream();
      test_overrun();
      test_reset_mid_frame();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
